shift_rows_seq: RTL and testbench
=================================

// Module: shift_rows_seq
// PURPOSE
//  Sequencer directly downstream of the SubBytes state RAM (16 x 8).
//  Reads the 16 substituted state bytes over the RAM read port, applies the
//  AES ShiftRows byte permutation by address generation, and writes the
//  permuted bytes in order to the next stage's (MixColumns) state RAM write port.
//  One start -> one 16-byte pass; start/busy/done handshake to the round controller.
// PARAMETERS
//  DATA_W  8  width of one state byte on rd_data / wr_data
// PORTS
//  clk       in   1       single clock, all state on rising edge
//  rst       in   1       asynchronous, active-low reset
//  start     in   1       1-cycle request to permute one full state
//  busy      out  1       high while a pass is in progress
//  done      out  1       1-cycle pulse when last byte has been written
//  rd_en     out  1       read enable to SubBytes RAM (R_En)
//  rd_addr   out  4       read address to SubBytes RAM (addr_out)
//  rd_data   in   DATA_W  registered RAM output, valid 1 cycle after rd_en
//  wr_en     out  1       write enable to downstream state RAM
//  wr_addr   out  4       write address, 0..15 ascending
//  wr_data   out  DATA_W  permuted byte
//  inv       in   1       only with INV_SHIFT_EN: 1 = InvShiftRows
// BEHAVIOUR
//  - Byte index k = r + 4*c (column-major), r = k[1:0], c = k[3:2].
//  - Forward: rd_addr for output k = r + 4*((c + r) mod 4); mod-4 by 2-bit wrap.
//  - Reset (rst=0, async): state IDLE, k=0, busy=0, done=0, rd_en=0,
//    rd_addr=0, wr_en=0, wr_addr=0, wr_data=0. Reset mid-pass aborts, no done.
//  - FSM IDLE -> READ on start; READ -> DRAIN after k=15 issued;
//    DRAIN -> DONE after last write issued; DONE -> IDLE unconditionally.
//  - Edge E0 samples start in IDLE: busy=1, rd_en=1, rd_addr=map(0).
//  - rd_en high exactly 16 cycles (E0..E15 outputs), rd_addr=map(k), k=0..15.
//  - Pipeline: read sampled by RAM at E(k+1); rd_data valid after E(k+1);
//    captured at E(k+2) into wr_data, wr_addr=k, wr_en=1 (all registered).
//  - wr_en high 16 consecutive cycles (after E2..E17), wr_addr ascends 0..15.
//  - done=1 for exactly one cycle after E18; busy falls at same edge.
//    Fixed latency start->done = 18 cycles.
//  - start while busy or done is high: ignored, no queueing.
//  - start asserted in the same cycle done is high: ignored; a new pass
//    requires start in IDLE.
//  - Counter k is 4 bits; wraps 15->0 only on transition to DRAIN; never
//    exceeds one pass.
//  - rd_data is sampled only in the pipeline slot following a rd_en; value
//    at other times is don't-care and must not reach wr_data while wr_en=0
//    (wr_data holds last written value).
// CONFIGURATION
//  INV_SHIFT_EN defined: port inv exists; inv is latched at the start edge
//    and held for the pass; inv=1 maps rd_addr = r + 4*((c - r) mod 4)
//    (decryption); changing inv mid-pass has no effect.
//  INV_SHIFT_EN undefined: no inv port; forward ShiftRows only.
// TESTING
//  1. Reset: rst=0 mid-pass -> all outputs 0 at once; after release, no done,
//     no wr_en until next start.
//  2. RAM preloaded bytes 0x00..0x0F at addr 0..15, start pulse -> wr_data
//     sequence 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B at wr_addr 0..15.
//  3. Latency: start at cycle 0 -> rd_en cycles 1..16, wr_en cycles 3..18,
//     done pulse cycle 19, busy high cycles 1..18.
//  4. start re-pulsed at cycles 5 and 19 -> ignored; exactly 16 writes, one done.
//  5. Back-to-back: start at cycle 20 (IDLE) -> second identical pass, 16 writes.
//  6. INV_SHIFT_EN, inv=1, same preload -> sequence 00,0D,0A,07,04,01,0E,0B,
//     08,05,02,0F,0C,09,06,03; toggling inv mid-pass leaves output unchanged.

Source files
------------

// File: rtl/shift_rows_seq.sv
// shift_rows_seq: streams 16 state bytes through AES ShiftRows by read-address permutation.
// Optional INV_SHIFT_EN adds port inv_i selecting InvShiftRows, latched per pass.
module shift_rows_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef INV_SHIFT_EN
  input  logic              inv_i,
`endif
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [3:0]        rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [3:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] k_q, k_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic rd_en_q, rd_en_d, vld_q, wr_en_q;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic inv_cur;
`ifdef INV_SHIFT_EN
  logic inv_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inv_q <= 1'b0;
    else if (state_q == IDLE && start_i) inv_q <= inv_i;
  assign inv_cur = (state_q == IDLE) ? inv_i : inv_q;
`else
  assign inv_cur = 1'b0;
`endif
  // Row r rotates by r columns: left for encrypt, right for decrypt.
  function automatic logic [3:0] map(input logic [3:0] k, input logic inv);
    return {inv ? k[3:2] - k[1:0] : k[3:2] + k[1:0], k[1:0]};
  endfunction
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d   = READ;
        k_d       = 4'd0;
        rd_en_d   = 1'b1;
        rd_addr_d = map(4'd0, inv_cur);
      end
      READ: if (k_q == 4'hf) begin
        state_d = DRAIN;
        k_d     = 4'd0;
      end else begin
        k_d       = k_q + 4'd1;
        rd_en_d   = 1'b1;
        rd_addr_d = map(k_q + 4'd1, inv_cur);
      end
      DRAIN: state_d = (wr_en_q && wr_addr_q == 4'hf) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // vld_q marks the cycle rd_data_i carries the byte read one cycle earlier.
  assign wr_data_d = vld_q ? rd_data_i : wr_data_q;
  assign wr_addr_d = vld_q ? (wr_en_q ? wr_addr_q + 4'd1 : 4'd0) : wr_addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= 4'd0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 4'd0;
      vld_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= rd_en_q;
      wr_en_q   <= vld_q;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  assign busy_o    = state_q == READ || state_q == DRAIN;
  assign done_o    = state_q == DONE;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
endmodule

// File: tb/tb_shift_rows_seq.sv
// tb_shift_rows_seq: directed bench for shift_rows_seq with a registered 16x8 source RAM.
module tb_shift_rows_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [3:0] rd_addr, wr_addr;
  logic [7:0] rd_data = 8'h00, wr_data;
  logic [7:0] mem [16];
  int n_chk = 0, n_fail = 0;
`ifdef INV_SHIFT_EN
  logic inv = 1'b0;
`endif
  logic [7:0] fwd_tab [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  logic [7:0] inv_tab [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  shift_rows_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_SHIFT_EN
    .inv_i(inv),
`endif
    .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " rd_addr"}, rd_addr, 0);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " wr_addr"}, wr_addr, 0);
    chk({tag, " wr_data"}, wr_data, 0);
  endtask

  // start must already be high in cycle 0; cycle n is checked mid-period after edge n-1.
  task automatic run_pass(input logic [7:0] tab [16], input bit chain);
    int writes = 0, dones = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("c%0d busy", n), busy, (n <= 18) ? 1 : 0);
      chk($sformatf("c%0d rd_en", n), rd_en, (n <= 16) ? 1 : 0);
      if (n <= 16) chk($sformatf("c%0d rd_addr", n), rd_addr, tab[n-1]);
      chk($sformatf("c%0d wr_en", n), wr_en, (n >= 3 && n <= 18) ? 1 : 0);
      if (n >= 3 && n <= 18) begin
        chk($sformatf("c%0d wr_addr", n), wr_addr, n - 3);
        chk($sformatf("c%0d wr_data", n), wr_data, tab[n-3]);
      end else if (n > 18) chk($sformatf("c%0d wr_data hold", n), wr_data, tab[15]);
      chk($sformatf("c%0d done", n), done, (n == 19) ? 1 : 0);
      if (wr_en) writes++;
      if (done) dones++;
      start = (n == 5 || n == 19 || (n == 20 && chain));
`ifdef INV_SHIFT_EN
      if (n == 6) inv = ~inv;
`endif
    end
    chk("pass writes", writes, 16);
    chk("pass dones", dones, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midpass wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (wr_en || done || busy) begin
        chk("post-reset idle", {busy, done, wr_en}, 0);
      end
    end
    chk("post-reset quiet", {busy, done, wr_en, rd_en}, 0);
    start = 1'b1;
    run_pass(fwd_tab, 1'b1);
    run_pass(fwd_tab, 1'b0);
`ifdef INV_SHIFT_EN
    @(negedge clk);
    inv = 1'b1;
    start = 1'b1;
    run_pass(inv_tab, 1'b0);
    @(negedge clk);
    start = 1'b1;
    run_pass(fwd_tab, 1'b0);
`else
    chk("inv table unused", inv_tab[1], 8'h0D);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
